// File: rtl/tick_monitor.sv
`default_nettype none
//------------------------------------------------------------------------------
// tick_monitor : checks tick spacing against PERIOD+/-TOL, tracks lock, flags
//                early/missing ticks and counts accepted ticks.
// Revision     : 1.0
//------------------------------------------------------------------------------
module tick_monitor #(
    parameter int PERIOD    = 400001,
    parameter int TOL       = 2,
    parameter int CBITS     = 20,
    parameter int LOCK_GOOD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             tick,
    input  logic             clr_sticky,
    output logic             locked,
    output logic             early,
    output logic             missed,
    output logic             err_sticky,
    output logic [CBITS-1:0] last_interval,
    output logic [15:0]      tick_cnt
);

    localparam int GBITS = $clog2(LOCK_GOOD + 1);

    localparam logic [CBITS-1:0] C_LO        = CBITS'(PERIOD - TOL);
    localparam logic [CBITS-1:0] C_HI        = CBITS'(PERIOD + TOL);
    localparam logic [CBITS-1:0] C_SAT       = CBITS'(PERIOD + TOL + 1);
    localparam logic [GBITS-1:0] C_LOCK_LAST = GBITS'(LOCK_GOOD - 1);
    localparam logic [GBITS-1:0] C_LOCK_GOOD = GBITS'(LOCK_GOOD);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACQ   = 2'd1;
    localparam logic [1:0] S_TRACK = 2'd2;
    localparam logic [1:0] S_LOCK  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [GBITS-1:0] good_run_q, good_run_d;
    logic             early_q, missed_q, err_q;
    logic [CBITS-1:0] last_q;
    logic [15:0]      tcnt_q;

    logic w_active, w_judge, w_good, w_early, w_timeout;

    // The timeout fires at C_HI, so a judged tick never sees an interval above it.
    always_comb begin
        w_active  = (state_q == S_TRACK) || (state_q == S_LOCK);
        w_judge   = enable && w_active && tick;
        w_good    = w_judge && (cnt_q >= C_LO) && (cnt_q <= C_HI);
        w_early   = w_judge && (cnt_q < C_LO);
        w_timeout = enable && w_active && !tick && (cnt_q == C_HI);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_ACQ;
                S_ACQ:   if (tick) state_d = S_TRACK;
                S_TRACK: begin
                    if (w_timeout)
                        state_d = S_ACQ;
                    else if (w_good && (good_run_q == C_LOCK_LAST))
                        state_d = S_LOCK;
                end
                S_LOCK: begin
                    if (w_timeout)
                        state_d = S_ACQ;
                    else if (w_early)
                        state_d = S_TRACK;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        locked        = (state_q == S_LOCK);
        early         = early_q;
        missed        = missed_q;
        err_sticky    = err_q;
        last_interval = last_q;
        tick_cnt      = tcnt_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!enable)
            cnt_d = '0;
        else if (tick && (state_q != S_IDLE))
            cnt_d = {{(CBITS-1){1'b0}}, 1'b1};
        else if (cnt_q != C_SAT)
            cnt_d = cnt_q + 1'b1;

        good_run_d = good_run_q;
        if (!enable || w_early || w_timeout || ((state_q == S_ACQ) && tick))
            good_run_d = '0;
        else if ((state_q == S_TRACK) && w_good && (good_run_q != C_LOCK_GOOD))
            good_run_d = good_run_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            good_run_q <= '0;
            early_q    <= 1'b0;
            missed_q   <= 1'b0;
            err_q      <= 1'b0;
            last_q     <= '0;
            tcnt_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            good_run_q <= good_run_d;
            early_q    <= w_early;
            missed_q   <= w_timeout;
            if (w_judge)
                last_q <= cnt_q;
            if (w_good)
                tcnt_q <= tcnt_q + 16'd1;
            // A fault seen in LOCK beats a clear requested in the same cycle.
            if ((w_early || w_timeout) && (state_q == S_LOCK))
                err_q <= 1'b1;
            else if (clr_sticky)
                err_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_monitor.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_tick_monitor : table of tick-spacing steps with queued expected outputs,
//                   plus hand-written async-reset sequence.
// Revision        : 1.0
//------------------------------------------------------------------------------
module tb_tick_monitor;

    localparam int PERIOD    = 10;
    localparam int TOL       = 1;
    localparam int CBITS     = 5;
    localparam int LOCK_GOOD = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable = 1'b0;
    logic             tick = 1'b0;
    logic             clr_sticky = 1'b0;
    logic             locked, early, missed, err_sticky;
    logic [CBITS-1:0] last_interval;
    logic [15:0]      tick_cnt;

    tick_monitor #(
        .PERIOD(PERIOD), .TOL(TOL), .CBITS(CBITS), .LOCK_GOOD(LOCK_GOOD)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick),
        .clr_sticky(clr_sticky), .locked(locked), .early(early),
        .missed(missed), .err_sticky(err_sticky),
        .last_interval(last_interval), .tick_cnt(tick_cnt)
    );

    always #5 clk = ~clk;

    // gap = cycles in the step; if tk, the last cycle carries the tick
    typedef struct {
        bit               en;
        int               gap;
        bit               tk;
        bit               clr;
        bit               l, e, m, s;
        logic [15:0]      cnt;
        logic [CBITS-1:0] last;
    } step_t;

    typedef struct {
        int               idx;
        bit               l, e, m, s;
        logic [15:0]      cnt;
        logic [CBITS-1:0] last;
    } exp_t;

    exp_t  sb[$];
    step_t vec[$];
    int    checks = 0;
    int    errors = 0;

    function automatic step_t mk(bit en, int gap, bit tk, bit clr, bit l, bit e,
                                 bit m, bit s, int cnt, int last);
        step_t r;
        r.en = en; r.gap = gap; r.tk = tk; r.clr = clr;
        r.l = l; r.e = e; r.m = m; r.s = s;
        r.cnt = 16'(cnt); r.last = CBITS'(last);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_step(input step_t s, input int idx);
        exp_t x;
        for (int c = 1; c <= s.gap; c++) begin
            enable     = s.en;
            tick       = (c == s.gap) && s.tk;
            clr_sticky = (c == s.gap) && s.clr;
            if (c == s.gap) begin
                x.idx = idx; x.l = s.l; x.e = s.e; x.m = s.m; x.s = s.s;
                x.cnt = s.cnt; x.last = s.last;
                sb.push_back(x);
            end
            @(posedge clk);
            @(negedge clk);
            if (c < s.gap)
                chk($sformatf("s%0d.c%0d.no_pulse", idx, c), {30'd0, early, missed}, 32'd0);
        end
        tick       = 1'b0;
        clr_sticky = 1'b0;
        if (sb.size() == 0) begin
            chk($sformatf("s%0d.scoreboard_empty", idx), 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            chk($sformatf("s%0d.locked", x.idx),        {31'd0, locked},       {31'd0, x.l});
            chk($sformatf("s%0d.early", x.idx),         {31'd0, early},        {31'd0, x.e});
            chk($sformatf("s%0d.missed", x.idx),        {31'd0, missed},       {31'd0, x.m});
            chk($sformatf("s%0d.err_sticky", x.idx),    {31'd0, err_sticky},   {31'd0, x.s});
            chk($sformatf("s%0d.tick_cnt", x.idx),      {16'd0, tick_cnt},     {16'd0, x.cnt});
            chk($sformatf("s%0d.last_interval", x.idx), 32'(last_interval),    32'(x.last));
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".locked"},        {31'd0, locked},     32'd0);
        chk({nm, ".early"},         {31'd0, early},      32'd0);
        chk({nm, ".missed"},        {31'd0, missed},     32'd0);
        chk({nm, ".err_sticky"},    {31'd0, err_sticky}, 32'd0);
        chk({nm, ".tick_cnt"},      {16'd0, tick_cnt},   32'd0);
        chk({nm, ".last_interval"}, 32'(last_interval),  32'd0);
    endtask

    initial begin
        //              en gap tk clr  l  e  m  s  cnt last
        vec.push_back(mk(1,  3, 1, 0,  0, 0, 0, 0,  0,  0));  // first tick, not judged
        vec.push_back(mk(1, 10, 1, 0,  0, 0, 0, 0,  1, 10));
        vec.push_back(mk(1, 10, 1, 0,  1, 0, 0, 0,  2, 10));  // lock
        vec.push_back(mk(1, 10, 1, 0,  1, 0, 0, 0,  3, 10));
        vec.push_back(mk(1,  7, 1, 0,  0, 1, 0, 1,  3,  7));  // early in lock
        vec.push_back(mk(1, 10, 1, 0,  0, 0, 0, 1,  4, 10));
        vec.push_back(mk(1, 10, 1, 0,  1, 0, 0, 1,  5, 10));
        vec.push_back(mk(1, 11, 0, 0,  0, 0, 1, 1,  5, 10));  // withheld -> missed
        vec.push_back(mk(1,  1, 0, 0,  0, 0, 0, 1,  5, 10));  // missed is one cycle
        vec.push_back(mk(1,  5, 1, 0,  0, 0, 0, 1,  5, 10));  // ACQ tick not judged
        vec.push_back(mk(1, 11, 1, 0,  0, 0, 0, 1,  6, 11));  // upper boundary good
        vec.push_back(mk(1,  9, 1, 0,  1, 0, 0, 1,  7,  9));  // lower boundary good
        vec.push_back(mk(1,  8, 1, 0,  0, 1, 0, 1,  7,  8));  // just below -> early
        vec.push_back(mk(1, 10, 1, 0,  0, 0, 0, 1,  8, 10));
        vec.push_back(mk(1, 10, 1, 0,  1, 0, 0, 1,  9, 10));
        vec.push_back(mk(1,  3, 1, 1,  0, 1, 0, 1,  9,  3));  // clr with early: set wins
        vec.push_back(mk(1,  1, 0, 1,  0, 0, 0, 0,  9,  3));  // clr alone
        vec.push_back(mk(1,  2, 1, 0,  0, 1, 0, 0,  9,  3));  // early in TRACK: no sticky
        vec.push_back(mk(1,  1, 1, 0,  0, 1, 0, 0,  9,  1));  // back-to-back ticks
        vec.push_back(mk(1, 10, 1, 0,  0, 0, 0, 0, 10, 10));
        vec.push_back(mk(1, 10, 1, 0,  1, 0, 0, 0, 11, 10));
        vec.push_back(mk(0,  1, 0, 0,  0, 0, 0, 0, 11, 10));  // disable
        vec.push_back(mk(0,  4, 1, 0,  0, 0, 0, 0, 11, 10));  // ticks ignored
        vec.push_back(mk(0, 10, 1, 0,  0, 0, 0, 0, 11, 10));
        vec.push_back(mk(1,  5, 1, 0,  0, 0, 0, 0, 11, 10));  // re-enable, first not judged
        vec.push_back(mk(1, 10, 1, 0,  0, 0, 0, 0, 12, 10));
        vec.push_back(mk(1, 10, 1, 0,  1, 0, 0, 0, 13, 10));

        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < vec.size(); i++)
            run_step(vec[i], i);

        // Asynchronous reset mid-interval while locked
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_reset.locked", {31'd0, locked}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        run_step(mk(1,  3, 1, 0, 0, 0, 0, 0, 0,  0), 100);
        run_step(mk(1, 10, 1, 0, 0, 0, 0, 0, 1, 10), 101);
        run_step(mk(1, 10, 1, 0, 1, 0, 0, 0, 2, 10), 102);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
